// File: rtl/demux4_router.sv
// Registered 1-to-4 write router: one producer beat is buffered and presented to
// exactly one of four consumers; a beat stalled too long is dropped with an err pulse.
module demux4_router #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [1:0]       err_sel,
  output logic             state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Handshake: a beat moves on a port in any cycle where valid and ready are both
  // high at the rising clock edge; valid never depends on ready, while in_ready
  // depends combinationally on the selected consumer's out_ready.

  state_t          state, state_nxt;
  logic [1:0]      sel_q, sel_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            err_nxt;
  logic [1:0]      err_sel_nxt;
  logic            accept, drain;

  assign drain     = (state == HOLD) && out_ready[sel_q];
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign state_dbg = state;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state == IDLE) ? 1'b1 : out_ready[sel_q];
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    data_nxt    = out_data;
    timer_nxt   = timer;
    err_nxt     = 1'b0;
    err_sel_nxt = err_sel;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HOLD;
          sel_nxt   = in_sel;
          data_nxt  = in_data;
          timer_nxt = '0;
        end
      end
      HOLD: begin
        if (drain) begin
          if (accept) begin
            sel_nxt   = in_sel;
            data_nxt  = in_data;
            timer_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timer == TIMER_LAST) begin
          // Drop the stalled beat; in_ready is already low, so nothing is accepted.
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          err_sel_nxt = sel_q;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= '0;
      out_data <= '0;
      timer    <= '0;
      err      <= 1'b0;
      err_sel  <= '0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      out_data <= data_nxt;
      timer    <= timer_nxt;
      err      <= err_nxt;
      err_sel  <= err_sel_nxt;
    end
  end

endmodule
